// File: rtl/perf_mon_pkg.sv
// Shared definitions for the ring report receiver.
//   - default widths and own-ID value used as parameter defaults
//   - beat offsets inside a ring report packet
//   - receiver FSM state encoding and error cause encoding
//   - helper that derives the payload beat count from the widths
package perf_mon_pkg;

  localparam int         DEF_AXIS_DIN_W = 8;
  localparam int         DEF_ID_W       = 8;
  localparam logic [7:0] DEF_ID         = 8'd0;
  localparam int         DEF_CLK_CNT_W  = 32;

  // Beat positions within a packet: dst ID, src ID, then the payload.
  localparam int BEAT_DST  = 0;
  localparam int BEAT_SRC  = BEAT_DST + 1;
  localparam int BEAT_PAY0 = BEAT_SRC + 1;

  typedef enum logic [2:0] {
    S_DST  = 3'd0,
    S_SRC  = 3'd1,
    S_PAY  = 3'd2,
    S_OUT  = 3'd3,
    S_DROP = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_DST   = 2'd1,
    ERR_SHORT = 2'd2,
    ERR_LONG  = 2'd3
  } err_code_t;

  // Number of payload beats carrying one counter value.
  function automatic int num_payload_beats(input int cnt_w, input int beat_w);
    return cnt_w / beat_w;
  endfunction

endpackage

// File: rtl/ring_report_rx.sv
// Ring report receiver: takes packets off the ring tail, keeps the ones
// addressed to this node and turns them into (source ID, counter value)
// reports with a valid/ready handshake. Malformed or foreign packets are
// swallowed and flagged with a one-cycle error pulse plus a sticky cause.
//
// Ports
//   clk_i, reset_ni    clock, asynchronous active-low reset
//   s_axis_*           ring tail beat stream (valid/ready/last/data)
//   rpt_valid_o/ready  decoded report handshake
//   rpt_src_o          ID of the reporting node
//   rpt_val_o          reported counter value
//   err_o              one-cycle pulse per error
//   err_code_o         cause of the most recent error (1 dst, 2 short, 3 long)
//   err_cnt_o          error count, saturating at 255
//   pkt_cnt_o          delivered report count, wrapping
module ring_report_rx
  import perf_mon_pkg::*;
#(
  parameter int              AXIS_DIN_W = DEF_AXIS_DIN_W,
  parameter int              ID_W       = DEF_ID_W,
  parameter logic [ID_W-1:0] ID         = ID_W'(DEF_ID),
  parameter int              CLK_CNT_W  = DEF_CLK_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic                  s_axis_tlast_i,
  input  logic [AXIS_DIN_W-1:0] s_axis_tdata_i,
  output logic                  rpt_valid_o,
  input  logic                  rpt_ready_i,
  output logic [ID_W-1:0]       rpt_src_o,
  output logic [CLK_CNT_W-1:0]  rpt_val_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [7:0]            err_cnt_o,
  output logic [15:0]           pkt_cnt_o
);

  localparam int                    NP        = num_payload_beats(CLK_CNT_W, AXIS_DIN_W);
  localparam int                    CNT_W     = $clog2(NP + 1);
  localparam int                    LAST_BEAT = BEAT_PAY0 + NP - 1;
  localparam logic [CNT_W-1:0]      LAST_PAY  = CNT_W'(LAST_BEAT - BEAT_PAY0);
  localparam logic [AXIS_DIN_W-1:0] ID_BEAT   = AXIS_DIN_W'(ID);

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CLK_CNT_W-1:0] shift_q, shift_d, shift_next;
  logic [ID_W-1:0]      src_q, src_d;
  err_code_t            pend_q, pend_d;
  err_code_t            err_cause;
  logic                 beat_acc;
  logic                 err_fire;
  logic                 rpt_load;
  logic                 rpt_take;

  // Ready is a pure state decode, forced low while reset is held.
  assign s_axis_tready_o = reset_ni && (state_q != S_OUT);
  assign beat_acc        = s_axis_tvalid_i && s_axis_tready_o;

  // First payload beat is shifted in first and so ends up as the MSB.
  assign shift_next = CLK_CNT_W'({shift_q, s_axis_tdata_i});

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    src_d      = src_q;
    pend_d     = pend_q;
    err_fire   = 1'b0;
    err_cause  = pend_q;
    rpt_load   = 1'b0;
    rpt_take   = 1'b0;

    case (state_q)
      S_DST: begin
        if (beat_acc) begin
          if (s_axis_tlast_i) begin
            err_fire  = 1'b1;
            err_cause = ERR_SHORT;
          end else if (s_axis_tdata_i == ID_BEAT) begin
            state_d = S_SRC;
          end else begin
            // Not ours: swallow the rest, report at its tlast.
            state_d = S_DROP;
            pend_d  = ERR_DST;
          end
        end
      end

      S_SRC: begin
        if (beat_acc) begin
          src_d = s_axis_tdata_i[ID_W-1:0];
          if (s_axis_tlast_i) begin
            err_fire  = 1'b1;
            err_cause = ERR_SHORT;
            state_d   = S_DST;
          end else begin
            state_d    = S_PAY;
            beat_cnt_d = '0;
            shift_d    = '0;
          end
        end
      end

      S_PAY: begin
        if (beat_acc) begin
          shift_d    = shift_next;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_PAY) begin
            if (s_axis_tlast_i) begin
              state_d  = S_OUT;
              rpt_load = 1'b1;
            end else begin
              state_d = S_DROP;
              pend_d  = ERR_LONG;
            end
          end else if (s_axis_tlast_i) begin
            // Early tlast: the partial value is simply never published.
            err_fire  = 1'b1;
            err_cause = ERR_SHORT;
            state_d   = S_DST;
          end
        end
      end

      S_OUT: begin
        if (rpt_valid_o && rpt_ready_i) begin
          rpt_take = 1'b1;
          state_d  = S_DST;
        end
      end

      S_DROP: begin
        if (beat_acc && s_axis_tlast_i) begin
          err_fire  = 1'b1;
          err_cause = pend_q;
          state_d   = S_DST;
        end
      end

      default: state_d = S_DST;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_DST;
      beat_cnt_q  <= '0;
      shift_q     <= '0;
      src_q       <= '0;
      pend_q      <= ERR_NONE;
      rpt_valid_o <= 1'b0;
      rpt_src_o   <= '0;
      rpt_val_o   <= '0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      err_cnt_o   <= '0;
      pkt_cnt_o   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      src_q      <= src_d;
      pend_q     <= pend_d;
      err_o      <= err_fire;

      if (err_fire) begin
        err_code_o <= err_cause;
        if (err_cnt_o != 8'hFF) begin
          err_cnt_o <= err_cnt_o + 8'd1;
        end
      end

      // Report registers are loaded once on the final payload beat and
      // left alone while waiting for the consumer.
      if (rpt_load) begin
        rpt_valid_o <= 1'b1;
        rpt_src_o   <= src_q;
        rpt_val_o   <= shift_next;
      end else if (rpt_take) begin
        rpt_valid_o <= 1'b0;
        pkt_cnt_o   <= pkt_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ring_report_rx.sv
// Self-checking bench for ring_report_rx at default parameters (ID=0,
// 8-bit beats, 32-bit values, four payload beats). A packet-level model
// classifies each received packet on its tlast and predicts the outputs;
// a compare process checks them on every falling edge, and directed
// scenarios add hand-computed literal checks.
module tb_ring_report_rx;

  localparam int         NP      = 4;
  localparam logic [7:0] OWN_ID  = 8'h00;
  localparam int         MAX_WAIT = 40;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        s_axis_tvalid_i = 1'b0;
  logic        s_axis_tready_o;
  logic        s_axis_tlast_i = 1'b0;
  logic [7:0]  s_axis_tdata_i = 8'h00;
  logic        rpt_valid_o;
  logic        rpt_ready_i = 1'b1;
  logic [7:0]  rpt_src_o;
  logic [31:0] rpt_val_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [7:0]  err_cnt_o;
  logic [15:0] pkt_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [8:0]  cur_pkt[$];
  logic        m_valid  = 1'b0;
  logic [7:0]  m_src    = 8'h00;
  logic [31:0] m_val    = 32'h0;
  logic        m_err    = 1'b0;
  logic [1:0]  m_code   = 2'd0;
  int          m_errcnt = 0;
  logic [15:0] m_pkt    = 16'h0;
  logic        preload  = 1'b0;

  logic [7:0]  pkt_q[$];

  ring_report_rx dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .rpt_valid_o     (rpt_valid_o),
    .rpt_ready_i     (rpt_ready_i),
    .rpt_src_o       (rpt_src_o),
    .rpt_val_o       (rpt_val_o),
    .err_o           (err_o),
    .err_code_o      (err_code_o),
    .err_cnt_o       (err_cnt_o),
    .pkt_cnt_o       (pkt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-packet classification: length and dst decide the outcome.
  task automatic classify();
    int          n;
    logic [1:0]  code;
    logic [31:0] v;
    n    = cur_pkt.size();
    code = 2'd0;
    if (n == 1)                          code = 2'd2;
    else if (cur_pkt[0][7:0] != OWN_ID)  code = 2'd1;
    else if (n < NP + 2)                 code = 2'd2;
    else if (n > NP + 2)                 code = 2'd3;
    if (code != 2'd0) begin
      m_err  = 1'b1;
      m_code = code;
      if (m_errcnt < 255) m_errcnt++;
    end else begin
      v = 32'h0;
      for (int k = 2; k < n; k++) v = (v << 8) | {24'h0, cur_pkt[k][7:0]};
      m_valid = 1'b1;
      m_src   = cur_pkt[1][7:0];
      m_val   = v;
    end
  endtask

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cur_pkt.delete();
      m_valid  = 1'b0;
      m_src    = 8'h00;
      m_val    = 32'h0;
      m_err    = 1'b0;
      m_code   = 2'd0;
      m_errcnt = 0;
      m_pkt    = 16'h0;
    end else begin
      m_err = 1'b0;
      if (preload) begin
        m_pkt = 16'hFFFF;
      end
      if (m_valid) begin
        if (rpt_ready_i) begin
          m_valid = 1'b0;
          m_pkt   = m_pkt + 16'd1;
        end
      end else if (s_axis_tvalid_i) begin
        cur_pkt.push_back({s_axis_tlast_i, s_axis_tdata_i});
        if (s_axis_tlast_i) begin
          classify();
          cur_pkt.delete();
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("tready", {63'h0, s_axis_tready_o}, {63'h0, reset_ni && !m_valid});
    check("rpt_valid", {63'h0, rpt_valid_o}, {63'h0, m_valid});
    if (m_valid) begin
      check("rpt_src", {56'h0, rpt_src_o}, {56'h0, m_src});
      check("rpt_val", {32'h0, rpt_val_o}, {32'h0, m_val});
    end
    check("err", {63'h0, err_o}, {63'h0, m_err});
    check("err_code", {62'h0, err_code_o}, {62'h0, m_code});
    check("err_cnt", {56'h0, err_cnt_o}, 64'(m_errcnt));
    if (!preload) check("pkt_cnt", {48'h0, pkt_cnt_o}, {48'h0, m_pkt});
  end

  task automatic add(input logic [7:0] v);
    pkt_q.push_back(v);
  endtask

  // Drives pkt_q beat by beat; called at posedge+1, returns at posedge+1
  // after the last beat was taken.
  task automatic send_pkt(input logic with_last);
    logic rdy;
    int   waited;
    for (int i = 0; i < pkt_q.size(); i++) begin
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i  = pkt_q[i];
      s_axis_tlast_i  = with_last && (i == pkt_q.size() - 1);
      waited = 0;
      forever begin
        @(negedge clk_i);
        rdy = s_axis_tready_o;
        @(posedge clk_i);
        #1;
        if (rdy) break;
        waited++;
        if (waited > MAX_WAIT) begin
          check("beat_accept_timeout", 64'(waited), 64'(MAX_WAIT));
          break;
        end
      end
    end
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i  = 1'b0;
    pkt_q.delete();
  endtask

  task automatic good_pkt(input logic [7:0] src, input logic [31:0] val);
    add(OWN_ID); add(src);
    add(val[31:24]); add(val[23:16]); add(val[15:8]); add(val[7:0]);
    send_pkt(1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_tready", {63'h0, s_axis_tready_o}, 64'h0);
    check("reset_pkt_cnt", {48'h0, pkt_cnt_o}, 64'h0);
    reset_ni = 1'b1;
    step(1);

    // Basic report, consumer always ready.
    add(8'h00); add(8'h02); add(8'hDE); add(8'hAD); add(8'hBE); add(8'hEF);
    send_pkt(1'b1);
    check("basic_valid", {63'h0, rpt_valid_o}, 64'h1);
    check("basic_src", {56'h0, rpt_src_o}, 64'h02);
    check("basic_val", {32'h0, rpt_val_o}, 64'hDEADBEEF);
    step(1);
    check("basic_pkt_cnt", {48'h0, pkt_cnt_o}, 64'h1);
    check("basic_valid_drop", {63'h0, rpt_valid_o}, 64'h0);

    // Foreign dst: dropped, one error pulse after its tlast.
    add(8'h05); add(8'h02); add(8'h11); add(8'h22); add(8'h33); add(8'h44);
    send_pkt(1'b1);
    check("dst_err_pulse", {63'h0, err_o}, 64'h1);
    check("dst_err_code", {62'h0, err_code_o}, 64'h1);
    check("dst_err_cnt", {56'h0, err_cnt_o}, 64'h1);
    step(1);
    check("dst_err_once", {63'h0, err_o}, 64'h0);
    check("dst_no_rpt", {63'h0, rpt_valid_o}, 64'h0);

    // Short, then long, then a good packet.
    add(8'h00); add(8'h01); add(8'hAA);
    send_pkt(1'b1);
    check("short_code", {62'h0, err_code_o}, 64'h2);
    add(8'h00); add(8'h01); add(8'h11); add(8'h22); add(8'h33); add(8'h44); add(8'h55);
    send_pkt(1'b1);
    check("long_code", {62'h0, err_code_o}, 64'h3);
    check("long_cnt", {56'h0, err_cnt_o}, 64'h3);
    good_pkt(8'h07, 32'h01020304);
    check("after_err_val", {32'h0, rpt_val_o}, 64'h01020304);
    step(1);

    // Back-pressure on the report side.
    rpt_ready_i = 1'b0;
    good_pkt(8'h09, 32'hCAFEF00D);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_hold_tready", {63'h0, s_axis_tready_o}, 64'h0);
      check("bp_hold_val", {32'h0, rpt_val_o}, 64'hCAFEF00D);
    end
    check("bp_hold_valid", {63'h0, rpt_valid_o}, 64'h1);
    rpt_ready_i = 1'b1;
    step(1);
    good_pkt(8'h0A, 32'h12345678);
    check("bp_next_src", {56'h0, rpt_src_o}, 64'h0A);
    step(1);
    check("bp_pkt_cnt", {48'h0, pkt_cnt_o}, 64'h4);

    // Error counter saturation with 300 one-beat packets.
    for (int i = 0; i < 300; i++) begin
      add(8'h01);
      send_pkt(1'b1);
    end
    step(1);
    check("err_sat", {56'h0, err_cnt_o}, 64'hFF);

    // Report counter wrap from FFFF.
    force dut.pkt_cnt_o = 16'hFFFF;
    preload = 1'b1;
    step(1);
    release dut.pkt_cnt_o;
    preload = 1'b0;
    good_pkt(8'h0B, 32'h0BADF00D);
    step(1);
    check("pkt_wrap", {48'h0, pkt_cnt_o}, 64'h0);
    check("err_sat_hold", {56'h0, err_cnt_o}, 64'hFF);

    // Reset during payload beat 3.
    add(8'h00); add(8'h02); add(8'h11); add(8'h22);
    send_pkt(1'b0);
    s_axis_tvalid_i = 1'b1;
    s_axis_tdata_i  = 8'h33;
    #2;
    reset_ni = 1'b0;
    @(posedge clk_i);
    #1;
    s_axis_tvalid_i = 1'b0;
    reset_ni = 1'b1;
    step(3);
    check("rst_no_rpt", {63'h0, rpt_valid_o}, 64'h0);
    check("rst_no_err", {56'h0, err_cnt_o}, 64'h0);
    good_pkt(8'h0C, 32'hFEEDFACE);
    check("rst_next_val", {32'h0, rpt_val_o}, 64'hFEEDFACE);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_report_rx.md
RING_REPORT_RX -- requirements
Module: ring_report_rx

Interface
REQ-001 The block SHALL have parameters: AXIS_DIN_W, 8, ring beat width; ID_W, 8, node ID width; ID, 8'd0, own ring ID; CLK_CNT_W, 32, reported counter width, a multiple of AXIS_DIN_W.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be (name, direction, width, meaning):
  clk_i  in  1  clock
  reset_ni  in  1  asynchronous active-low reset
  s_axis_tvalid_i  in  1  ring tail beat valid
  s_axis_tready_o  out  1  ring tail beat ready
  s_axis_tlast_i  in  1  last beat of packet
  s_axis_tdata_i  in  AXIS_DIN_W  beat data
  rpt_valid_o  out  1  decoded report valid
  rpt_ready_i  in  1  report consumer ready
  rpt_src_o  out  ID_W  ID of the reporting EU
  rpt_val_o  out  CLK_CNT_W  reported counter value
  err_o  out  1  one-cycle pulse on a malformed or unclaimed packet
  err_code_o  out  2  cause of the last error: 1 dst mismatch, 2 short, 3 long
  err_cnt_o  out  8  error count, saturating
  pkt_cnt_o  out  16  good reports delivered, wrapping

Function
REQ-004 Packet format SHALL be: beat0 dst ID; beat1 src ID; then NP = CLK_CNT_W/AXIS_DIN_W payload beats, MSB first; tlast on the final payload beat only (6 beats at default parameters).
REQ-005 A beat SHALL be accepted only when s_axis_tvalid_i and s_axis_tready_o are both high in the same cycle.
REQ-006 The FSM SHALL have states S_DST, S_SRC, S_PAY, S_OUT and S_DROP, with s_axis_tready_o high in every state except S_OUT.
REQ-007 S_DST SHALL handle an accepted beat as follows: tlast high gives a short error and stays in S_DST; tdata == ID goes to S_SRC; any other value goes to S_DROP with the error pending as dst mismatch.
REQ-008 S_SRC SHALL capture the src ID; tlast high gives a short error and returns to S_DST; otherwise it goes to S_PAY with the payload beat counter cleared.
REQ-009 S_PAY SHALL shift each accepted beat into the value register from the LSB side, so the first payload beat ends up as the MSB.
REQ-010 In S_PAY, tlast before beat NP SHALL give a short error and return to S_DST with the partial value discarded.
REQ-011 In S_PAY, beat NP with tlast SHALL go to S_OUT; beat NP without tlast SHALL go to S_DROP with the error pending as long.
REQ-012 S_DROP SHALL discard beats until an accepted tlast, then return to S_DST and pulse the pending error.
REQ-013 Every error SHALL raise err_o for exactly one cycle, in the cycle after the beat that resolves it.
REQ-014 On every error, err_code_o SHALL update and hold until the next error, and err_cnt_o SHALL increment, saturating at 255.
REQ-015 rpt_valid_o SHALL rise in the cycle after the final payload beat is accepted (latency 1).
REQ-016 While rpt_valid_o is high, rpt_src_o and rpt_val_o SHALL be stable and rpt_valid_o SHALL not drop until rpt_ready_i is high.
REQ-017 On a cycle with rpt_valid_o and rpt_ready_i both high, the block SHALL go to S_DST and pkt_cnt_o SHALL increment, wrapping 16'hFFFF to 0.
REQ-018 rpt_ready_i held high SHALL give a sustained rate of one report per NP+3 cycles; no beat is accepted while in S_OUT.
REQ-019 Every output SHALL be registered, except s_axis_tready_o, which is decoded from the state and gated by reset_ni.

Reset
REQ-020 While reset_ni is low, the block SHALL hold the state at S_DST and drive s_axis_tready_o, rpt_valid_o and err_o to 0.
REQ-021 While reset_ni is low, the block SHALL clear rpt_src_o, rpt_val_o, err_code_o, err_cnt_o, pkt_cnt_o and the beat counter to 0.
REQ-022 Reset asserted mid-packet or mid-report SHALL drop that packet or report with no error counted; the first beat after release SHALL be treated as beat0.

Structure
REQ-023 Package perf_mon_pkg SHALL hold the FSM state enum, the err_code enum, the beat-offset constants and the default ID and width constants.
REQ-024 The block SHALL be a single module with no sub-module; the saturating and wrapping counters are inline.

Verification
REQ-025 ID=0, beats 00,02,DE,AD,BE,EF with tlast on the last beat SHALL give, 1 cycle later, rpt_valid_o=1, rpt_src_o=02, rpt_val_o=DEADBEEF, and pkt_cnt_o=1 after the handshake.
REQ-026 A packet with dst=05 SHALL be dropped with err_o pulsing once after its tlast, err_code_o=1, err_cnt_o=1 and no report.
REQ-027 00,01,AA with tlast SHALL give err_code_o=2; a 7-beat packet SHALL give err_code_o=3; the next valid packet SHALL decode correctly.
REQ-028 rpt_ready_i held low for 10 cycles SHALL keep rpt_valid_o and its data stable with s_axis_tready_o=0, and the next packet SHALL be accepted after release.
REQ-029 300 malformed packets SHALL leave err_cnt_o=255; pkt_cnt_o starting at FFFF SHALL wrap to 0 after one good report.
REQ-030 reset_ni pulsed low during payload beat 3 SHALL give no report and no error, and a following good packet SHALL decode correctly.
